// File: rtl/vec_mac.sv
// Serial signed fixed-point dot product: bias + VECTOR products, round/saturate/ReLU.
// Result VECTOR+2 edges after start with gap-free samples; in_valid gaps stall the accumulator.
module vec_mac #(
  parameter int WIDTH  = 16,
  parameter int VECTOR = 4,
  parameter int FRAC   = 8,
  parameter int ACCW   = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] bias,
  input  logic             relu_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic [7:0]       addr
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [ACCW-1:0] HALF = ACCW'(1) << (FRAC-1);
  localparam logic [WIDTH-1:0] MAXW = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINW = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [7:0] LAST = 8'(VECTOR-1);

  state_t                  state;
  logic signed [ACCW-1:0]  acc;
  logic                    relu;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACCW-1:0]  prod_ext;
  logic signed [ACCW-1:0]  bias_ext;
  logic signed [ACCW-1:0]  rnd;
  logic signed [ACCW-1:0]  shifted;
  logic [WIDTH-1:0]        result;

  assign prod     = $signed(din) * $signed(w);
  assign prod_ext = {{(ACCW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign bias_ext = {{(ACCW-WIDTH){bias[WIDTH-1]}}, bias} <<< FRAC;
  assign rnd      = acc + HALF;
  assign shifted  = rnd >>> FRAC;

  // Saturation keeps the sign, so the ReLU test can use the unsaturated sign bit.
  always_comb begin
    result = shifted[WIDTH-1:0];
    if (shifted > MAXV)
      result = MAXW;
    else if (shifted < MINV)
      result = MINW;
    if (relu && shifted[ACCW-1])
      result = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      addr       <= '0;
      relu       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            state <= ACC;
            acc   <= bias_ext;
            addr  <= '0;
            relu  <= relu_en;
          end
        end
        ACC: begin
          busy <= 1'b1;
          if (in_valid) begin
            acc  <= acc + prod_ext;
            addr <= addr + 8'd1;
            if (addr == LAST)
              state <= OUT;
          end
        end
        OUT: begin
          busy       <= 1'b1;
          dout       <= result;
          dout_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mac.sv
// Directed bench for vec_mac with hand-computed Q8.8 results.
module tb_vec_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] w = '0;
  logic [15:0] bias = '0;
  logic        relu_en = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        busy;
  logic [7:0]  addr;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulse  = 0;

  vec_mac #(.WIDTH(16), .VECTOR(4), .FRAC(8), .ACCW(40)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .din(din), .w(w), .bias(bias), .relu_en(relu_en),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .addr(addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dout_valid) n_pulse++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a vector, feeds 4 samples (gap idle cycles between them), waits for the result.
  task automatic run_vec(input logic [15:0] b, input logic re,
                         input logic [63:0] dv, input logic [63:0] wv, input int gap,
                         output logic [15:0] res, output int edges);
    start = 1'b1; bias = b; relu_en = re;
    tick(); edges = 1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; din = dv[16*i +: 16]; w = wv[16*i +: 16];
      tick(); edges++;
      in_valid = 1'b0;
      if (i < 3) repeat (gap) begin tick(); edges++; end
    end
    while (!dout_valid && edges < 40) begin tick(); edges++; end
    if (!dout_valid) chk("timeout", 32'd0, 32'd1);
    res = dout;
  endtask

  logic [15:0] res;
  int          edges;
  int          p0;

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_vld", 32'(dout_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_addr", 32'(addr), 32'h0);

    // basic: 4 x (1.0*1.0) = 4.0
    run_vec(16'h0000, 1'b0, {4{16'h0100}}, {4{16'h0100}}, 0, res, edges);
    chk("basic_dout", 32'(res), 32'h0400);
    chk("basic_lat", 32'(edges), 32'd6);
    chk("basic_busy_vld", 32'(busy), 32'h1);
    tick();
    chk("basic_busy_after", 32'(busy), 32'h0);
    chk("basic_vld_after", 32'(dout_valid), 32'h0);

    // bias 0.5 + 4 x (-1.0) = -3.5 -> rounds to -3.5 = 0xFC80; second start lands in dout_valid cycle
    run_vec(16'h0080, 1'b0, {4{16'h0100}}, {4{16'hFF00}}, 0, res, edges);
    chk("bias_neg", 32'(res), 32'hFC80);
    run_vec(16'h0080, 1'b1, {4{16'h0100}}, {4{16'hFF00}}, 0, res, edges);
    chk("bias_relu", 32'(res), 32'h0000);
    chk("b2b_lat", 32'(edges), 32'd6);

    // rounding: product 0x80 is exactly half an LSB
    run_vec(16'h0000, 1'b0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0080, 0, res, edges);
    chk("round_up", 32'(res), 32'h0001);
    run_vec(16'h0000, 1'b0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_FF80, 0, res, edges);
    chk("round_neg_half", 32'(res), 32'h0000);

    // saturation both ways
    run_vec(16'h0000, 1'b0, {4{16'h7FFF}}, {4{16'h7FFF}}, 0, res, edges);
    chk("sat_pos", 32'(res), 32'h7FFF);
    run_vec(16'h0000, 1'b0, {4{16'h8000}}, {4{16'h7FFF}}, 0, res, edges);
    chk("sat_neg", 32'(res), 32'h8000);

    // gaps, IDLE data ignored, mid-vector start ignored
    tick(); tick();
    p0 = n_pulse;
    in_valid = 1'b1; din = 16'h7FFF; w = 16'h7FFF;
    tick(); tick();
    start = 1'b1; bias = 16'h0000; relu_en = 1'b0;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("gap_addr0", 32'(addr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; din = 16'h0100; w = 16'h0100;
      tick();
      in_valid = 1'b0;
      chk($sformatf("gap_addr%0d", i + 1), 32'(addr), 32'(i + 1));
      if (i < 3) for (int j = 0; j < 3; j++) begin
        if (i == 1 && j == 1) start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    edges = 0;
    while (!dout_valid && edges < 20) begin tick(); edges++; end
    chk("gap_seen", 32'(dout_valid), 32'h1);
    chk("gap_dout", 32'(dout), 32'h0400);
    repeat (6) tick();
    chk("gap_pulses", 32'(n_pulse - p0), 32'd1);

    // reset mid-vector with large partial sums
    start = 1'b1; bias = 16'h1234; relu_en = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; din = 16'h7FFF; w = 16'h7FFF;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_dout", 32'(dout), 32'h0);
    chk("mid_rst_vld", 32'(dout_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_addr", 32'(addr), 32'h0);
    run_vec(16'h0000, 1'b0, {4{16'h0100}}, {4{16'h0100}}, 0, res, edges);
    chk("post_rst_dout", 32'(res), 32'h0400);
    chk("post_rst_lat", 32'(edges), 32'd6);

    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
